// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the multi-requester UART transmitter.
package uart_arb_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE = 2'd0,
      ARB_SEND = 2'd1,
      ARB_HOLD = 2'd2
   } arb_state_e;

   // start + 8 data + stop
   localparam int FRAME_BITS = 10;

   localparam logic [7:0] NEWLINE = 8'h0A;

   // Width of an index/counter able to hold 0..n-1, never narrower than one bit.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/uart_tx_serializer.sv
// 8N1 serializer: start bit, eight data bits LSB first, stop bit, each held
// CYCLES_PER_SYMBOL clocks. The shift register's low bit is the line itself,
// so the output is registered and glitch free.
module uart_tx_serializer
   import uart_arb_pkg::*;
#(
   parameter int CYCLES_PER_SYMBOL = 434
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       start_i,
   input  logic [7:0] data_i,
   output logic       tx_o,
   output logic       done_o
);

   localparam int CW = idx_width(CYCLES_PER_SYMBOL);
   localparam int BW = idx_width(FRAME_BITS);
   localparam logic [CW-1:0] LAST_CYC = CW'(CYCLES_PER_SYMBOL - 1);
   localparam logic [BW-1:0] LAST_BIT = BW'(FRAME_BITS - 1);

   logic [FRAME_BITS-1:0] r_shift;
   logic [BW-1:0]         r_bit_cnt;
   logic [CW-1:0]         r_cyc_cnt;
   logic                  r_active;
   logic                  w_sym_end;

   assign w_sym_end = r_active && (r_cyc_cnt == LAST_CYC);
   assign done_o    = w_sym_end && (r_bit_cnt == LAST_BIT);
   assign tx_o      = r_shift[0];

   // Load a frame on start, then shift one symbol out every CYCLES_PER_SYMBOL clocks.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_shift   <= '1;
         r_bit_cnt <= '0;
         r_cyc_cnt <= '0;
         r_active  <= 1'b0;
      end else if (start_i) begin
         r_shift   <= {1'b1, data_i, 1'b0};
         r_bit_cnt <= '0;
         r_cyc_cnt <= '0;
         r_active  <= 1'b1;
      end else if (r_active) begin
         if (w_sym_end) begin
            r_cyc_cnt <= '0;
            r_shift   <= {1'b1, r_shift[FRAME_BITS-1:1]};
            if (r_bit_cnt == LAST_BIT) begin
               r_active <= 1'b0;
            end else begin
               r_bit_cnt <= r_bit_cnt + 1'b1;
            end
         end else begin
            r_cyc_cnt <= r_cyc_cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART TX line among NUM_REQ byte producers. Bytes are granted
// round-robin; with LINE_LOCK the current owner keeps the line until it sends
// a newline or stays idle for LOCK_TIMEOUT cycles, so text lines never mix.
module uart_tx_arbiter
   import uart_arb_pkg::*;
#(
   parameter int  NUM_REQ      = 4,
   parameter int  BAUD         = 115200,
   parameter int  FREQ         = 50000000,
   parameter int  LINE_LOCK    = 1,
   parameter int  LOCK_TIMEOUT = 4096,
   localparam int IW           = idx_width(NUM_REQ)
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic [NUM_REQ-1:0]   req_valid_i,
   input  logic [NUM_REQ*8-1:0] req_data_i,
   output logic [NUM_REQ-1:0]   req_ready_o,
   output logic                 tx_o,
   output logic                 busy_o,
   output logic [IW-1:0]        grant_o
);

   localparam int            CYCLES_PER_SYMBOL = FREQ / BAUD;
   localparam int            IW1       = IW + 1;
   localparam int            TW        = idx_width(LOCK_TIMEOUT);
   localparam logic [IW-1:0] LAST_REQ  = IW'(NUM_REQ - 1);
   localparam logic [IW:0]   NUM_REQ_W = IW1'(NUM_REQ);
   localparam logic [TW-1:0] LAST_IDLE = TW'(LOCK_TIMEOUT - 1);

   if (CYCLES_PER_SYMBOL < 2) begin : g_chk_cps
      $error("uart_tx_arbiter: FREQ/BAUD must be at least 2");
   end
   if (NUM_REQ < 1 || LOCK_TIMEOUT < 1) begin : g_chk_params
      $error("uart_tx_arbiter: NUM_REQ and LOCK_TIMEOUT must be at least 1");
   end

   arb_state_e         r_state, w_state_next;
   logic [IW-1:0]      r_rr_ptr, w_rr_next;
   logic [IW-1:0]      r_grant;
   logic [7:0]         r_byte;
   logic [TW-1:0]      r_idle_cnt, w_idle_next;
   logic [IW-1:0]      w_cand [NUM_REQ];
   logic [IW-1:0]      w_winner, w_accept_idx;
   logic               w_any_valid, w_accept, w_done, w_tx;
   logic [NUM_REQ-1:0] w_ready;
   logic [7:0]         w_accept_data;

   function automatic logic [IW-1:0] next_req(input logic [IW-1:0] g);
      return (g == LAST_REQ) ? '0 : g + 1'b1;
   endfunction

   // Candidate gi is the requester gi places after the round-robin pointer, wrapped.
   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
      logic [IW:0] w_sum;
      assign w_sum       = {1'b0, r_rr_ptr} + IW1'(gi);
      assign w_cand[gi]  = (w_sum >= NUM_REQ_W) ? IW'(w_sum - NUM_REQ_W) : w_sum[IW-1:0];
   end

   // Winner is the valid candidate closest to the pointer (scan backwards, last hit wins).
   always_comb begin
      w_any_valid = 1'b0;
      w_winner    = r_rr_ptr;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         if (req_valid_i[w_cand[k]]) begin
            w_any_valid = 1'b1;
            w_winner    = w_cand[k];
         end
      end
   end

   // Next-state, ready and pointer logic for the IDLE/SEND/HOLD controller.
   always_comb begin
      w_state_next = r_state;
      w_rr_next    = r_rr_ptr;
      w_idle_next  = r_idle_cnt;
      w_ready      = '0;
      w_accept     = 1'b0;
      w_accept_idx = r_grant;
      case (r_state)
         ARB_IDLE: begin
            if (w_any_valid) begin
               w_ready[w_winner] = 1'b1;
               w_accept_idx      = w_winner;
               w_accept          = 1'b1;
               w_state_next      = ARB_SEND;
            end
         end
         ARB_SEND: begin
            if (w_done) begin
               if (LINE_LOCK != 0 && r_byte != NEWLINE) begin
                  w_state_next = ARB_HOLD;
                  w_idle_next  = '0;
               end else begin
                  w_state_next = ARB_IDLE;
                  w_rr_next    = next_req(r_grant);
               end
            end
         end
         ARB_HOLD: begin
            w_ready[r_grant] = 1'b1;
            if (req_valid_i[r_grant]) begin
               w_accept     = 1'b1;
               w_state_next = ARB_SEND;
            end else if (r_idle_cnt == LAST_IDLE) begin
               w_state_next = ARB_IDLE;
               w_rr_next    = next_req(r_grant);
            end else begin
               w_idle_next = r_idle_cnt + 1'b1;
            end
         end
         default: w_state_next = ARB_IDLE;
      endcase
   end

   assign w_accept_data = req_data_i[{w_accept_idx, 3'b000} +: 8];

   // Controller state; the accepted byte is kept so the newline test can run at end of frame.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state    <= ARB_IDLE;
         r_rr_ptr   <= '0;
         r_grant    <= '0;
         r_byte     <= '0;
         r_idle_cnt <= '0;
      end else begin
         r_state    <= w_state_next;
         r_rr_ptr   <= w_rr_next;
         r_idle_cnt <= w_idle_next;
         if (w_accept) begin
            r_grant <= w_accept_idx;
            r_byte  <= w_accept_data;
         end
      end
   end

   uart_tx_serializer #(
      .CYCLES_PER_SYMBOL(CYCLES_PER_SYMBOL)
   ) u_serializer (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .start_i(w_accept),
      .data_i (w_accept_data),
      .tx_o   (w_tx),
      .done_o (w_done)
   );

   assign tx_o        = w_tx;
   assign busy_o      = (r_state != ARB_IDLE);
   assign grant_o     = r_grant;
   assign req_ready_o = w_ready;

   // A requester that is waiting must keep its request up until it is served.
   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_proto
      a_hold_valid: assert property (@(posedge clk_i) disable iff (!rst_ni)
         (req_valid_i[gi] && !req_ready_o[gi]) |=> req_valid_i[gi])
         else $error("requester %0d dropped valid before transfer", gi);
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: one instance without line lock, one with a short
// lock timeout; both at 8 clocks per bit. Expected frames go into a scoreboard
// queue as stimulus is planned and are popped as the line monitor decodes them.
module tb_uart_tx_arbiter;

   localparam int NREQ    = 4;
   localparam int CPS     = 8;
   localparam int TIMEOUT = 16;
   localparam int SPACING = 10 * CPS + 1;

   typedef logic [7:0] bytes_t [4];
   typedef struct {
      int         dut;
      logic [7:0] data;
      int         grant;
      int         gap;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic              a_rst_n, b_rst_n;
   logic [NREQ-1:0]   a_valid, b_valid, a_ready, b_ready;
   logic [NREQ*8-1:0] a_data, b_data;
   logic              a_tx, b_tx, a_busy, b_busy;
   logic [1:0]        a_grant, b_grant;

   exp_t sb_q[$];
   int   errors = 0;
   int   checks = 0;

   uart_tx_arbiter #(
      .NUM_REQ(NREQ), .BAUD(100), .FREQ(800), .LINE_LOCK(0), .LOCK_TIMEOUT(TIMEOUT)
   ) u_dut_rr (
      .clk_i(clk), .rst_ni(a_rst_n), .req_valid_i(a_valid), .req_data_i(a_data),
      .req_ready_o(a_ready), .tx_o(a_tx), .busy_o(a_busy), .grant_o(a_grant)
   );

   uart_tx_arbiter #(
      .NUM_REQ(NREQ), .BAUD(100), .FREQ(800), .LINE_LOCK(1), .LOCK_TIMEOUT(TIMEOUT)
   ) u_dut_lock (
      .clk_i(clk), .rst_ni(b_rst_n), .req_valid_i(b_valid), .req_data_i(b_data),
      .req_ready_o(b_ready), .tx_o(b_tx), .busy_o(b_busy), .grant_o(b_grant)
   );

   function automatic logic get_tx(input int d);
      return (d == 0) ? a_tx : b_tx;
   endfunction

   function automatic logic get_ready(input int d, input int r);
      return (d == 0) ? a_ready[r] : b_ready[r];
   endfunction

   function automatic int get_grant(input int d);
      return (d == 0) ? int'(a_grant) : int'(b_grant);
   endfunction

   task automatic set_req(input int d, input int r, input logic v, input logic [7:0] data);
      if (d == 0) begin
         a_valid[r]       = v;
         a_data[8*r +: 8] = data;
      end else begin
         b_valid[r]       = v;
         b_data[8*r +: 8] = data;
      end
   endtask

   task automatic expect_byte(input int d, input logic [7:0] data, input int grant, input int gap);
      exp_t e;
      e.dut   = d;
      e.data  = data;
      e.grant = grant;
      e.gap   = gap;
      sb_q.push_back(e);
   endtask

   task automatic reset_dut(input int d);
      @(posedge clk);
      #1;
      if (d == 0) begin
         a_rst_n = 1'b0; a_valid = '0; a_data = '0;
      end else begin
         b_rst_n = 1'b0; b_valid = '0; b_data = '0;
      end
      repeat (3) @(posedge clk);
      #1;
      if (d == 0) a_rst_n = 1'b1;
      else        b_rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   // Requester model: offers n bytes in order, each held until the handshake.
   task automatic drive_req(input int d, input int r, input bytes_t seq, input int n, input int delay);
      repeat (delay) @(posedge clk);
      #1;
      for (int i = 0; i < n; i++) begin
         bit got;
         got = 1'b0;
         set_req(d, r, 1'b1, seq[i]);
         for (int w = 0; w < 3000; w++) begin
            @(negedge clk);
            if (get_ready(d, r)) begin
               got = 1'b1;
               break;
            end
         end
         checks++;
         if (!got) begin
            errors++;
            $display("FAIL handshake dut%0d req%0d: no ready within 3000 cycles for byte %h", d, r, seq[i]);
            set_req(d, r, 1'b0, 8'h00);
            return;
         end
         @(posedge clk);
         #1;
      end
      set_req(d, r, 1'b0, 8'h00);
   endtask

   // Line monitor: decodes n frames at mid-bit and checks them against the scoreboard.
   task automatic consume(input int n);
      int last_start;
      last_start = 0;
      for (int i = 0; i < n; i++) begin
         exp_t       e;
         logic [9:0] bits;
         int         t0, gnt;
         bit         seen;
         if (sb_q.size() == 0) break;
         e    = sb_q.pop_front();
         seen = 1'b0;
         for (int w = 0; w < 3000; w++) begin
            @(negedge clk);
            if (get_tx(e.dut) == 1'b0) begin
               seen = 1'b1;
               break;
            end
         end
         checks++;
         if (!seen) begin
            errors++;
            $display("FAIL frame_start dut%0d: no start bit seen, required byte %h", e.dut, e.data);
            continue;
         end
         t0  = cyc;
         gnt = get_grant(e.dut);
         repeat (3) @(negedge clk);
         bits[0] = get_tx(e.dut);
         for (int k = 1; k < 10; k++) begin
            repeat (CPS) @(negedge clk);
            bits[k] = get_tx(e.dut);
         end
         $display("dut%0d frame: byte=%h grant=%0d start_cycle=%0d", e.dut, bits[8:1], gnt, t0);
         checks++;
         if ({bits[9], bits[0]} !== 2'b10) begin
            errors++;
            $display("FAIL framing dut%0d: stop/start=%b required 10", e.dut, {bits[9], bits[0]});
         end
         checks++;
         if (bits[8:1] !== e.data) begin
            errors++;
            $display("FAIL data dut%0d: got %h required %h", e.dut, bits[8:1], e.data);
         end
         checks++;
         if (gnt !== e.grant) begin
            errors++;
            $display("FAIL grant dut%0d: got %0d required %0d", e.dut, gnt, e.grant);
         end
         if (e.gap != 0) begin
            checks++;
            if (t0 - last_start != e.gap) begin
               errors++;
               $display("FAIL gap dut%0d: got %0d cycles required %0d", e.dut, t0 - last_start, e.gap);
            end
         end
         last_start = t0;
      end
   endtask

   task automatic test_reset();
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({a_tx, a_busy, a_ready, a_grant} !== 8'b1000_0000) begin
         errors++;
         $display("FAIL reset_hold: tx/busy/ready/grant=%b required 10000000", {a_tx, a_busy, a_ready, a_grant});
      end
      a_rst_n = 1'b1;
      b_rst_n = 1'b1;
      for (int c = 0; c < 100; c++) begin
         @(negedge clk);
         checks++;
         if ({a_tx, a_busy, a_ready, a_grant} !== 8'b1000_0000) begin
            errors++;
            $display("FAIL reset_idle dut0 cycle %0d: %b required 10000000", c, {a_tx, a_busy, a_ready, a_grant});
         end
         checks++;
         if ({b_tx, b_busy, b_ready, b_grant} !== 8'b1000_0000) begin
            errors++;
            $display("FAIL reset_idle dut1 cycle %0d: %b required 10000000", c, {b_tx, b_busy, b_ready, b_grant});
         end
      end
      $display("reset: 100 idle cycles checked on both instances");
   endtask

   task automatic test_pattern_55();
      logic [9:0] frame;
      logic       exp_tx, exp_busy;
      bit         got;
      frame = {1'b1, 8'h55, 1'b0};
      reset_dut(0);
      set_req(0, 0, 1'b1, 8'h55);
      got = 1'b0;
      for (int w = 0; w < 100; w++) begin
         @(negedge clk);
         if (a_ready[0]) begin
            got = 1'b1;
            break;
         end
      end
      checks++;
      if (!got) begin
         errors++;
         $display("FAIL pattern55_ready: ready[0]=%b required 1", a_ready[0]);
      end
      @(posedge clk);
      #1;
      set_req(0, 0, 1'b0, 8'h00);
      for (int c = 1; c <= 81; c++) begin
         @(negedge clk);
         exp_tx   = (c <= 80) ? frame[(c - 1) / 8] : 1'b1;
         exp_busy = (c <= 80);
         checks++;
         if (a_tx !== exp_tx || a_busy !== exp_busy) begin
            errors++;
            $display("FAIL pattern55 cycle %0d: tx=%b busy=%b required tx=%b busy=%b", c, a_tx, a_busy, exp_tx, exp_busy);
         end
      end
      checks++;
      if (a_grant !== 2'd0) begin
         errors++;
         $display("FAIL pattern55_grant: got %0d required 0", a_grant);
      end
      $display("pattern55: byte 55 waveform checked over 81 cycles");
   endtask

   task automatic test_round_robin();
      reset_dut(0);
      for (int r = 0; r < NREQ; r++) expect_byte(0, 8'(8'hA0 + r), r, (r == 0) ? 0 : SPACING);
      expect_byte(0, 8'hA0, 0, SPACING);
      a_data  = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
      a_valid = '1;
      consume(5);
      @(posedge clk);
      #1;
      a_rst_n = 1'b0;
      a_valid = '0;
      repeat (2) @(posedge clk);
      #1;
      a_rst_n = 1'b1;
   endtask

   task automatic test_line_lock();
      bytes_t hi, x;
      hi = '{8'h68, 8'h69, 8'h0A, 8'h00};
      x  = '{8'h58, 8'h00, 8'h00, 8'h00};
      reset_dut(1);
      expect_byte(1, 8'h68, 1, 0);
      expect_byte(1, 8'h69, 1, SPACING);
      expect_byte(1, 8'h0A, 1, SPACING);
      expect_byte(1, 8'h58, 0, SPACING);
      fork
         drive_req(1, 1, hi, 3, 0);
         drive_req(1, 0, x, 1, 5);
         consume(4);
      join
   endtask

   task automatic test_lock_timeout();
      bytes_t b2, b3;
      b2 = '{8'h41, 8'h00, 8'h00, 8'h00};
      b3 = '{8'h33, 8'h00, 8'h00, 8'h00};
      reset_dut(1);
      expect_byte(1, 8'h41, 2, 0);
      expect_byte(1, 8'h33, 3, SPACING + TIMEOUT);
      fork
         drive_req(1, 2, b2, 1, 0);
         drive_req(1, 3, b3, 1, 5);
         consume(2);
      join
   endtask

   task automatic test_reset_mid_frame();
      bytes_t b;
      bit     got;
      b = '{8'h3C, 8'h00, 8'h00, 8'h00};
      reset_dut(0);
      set_req(0, 1, 1'b1, 8'h3C);
      got = 1'b0;
      for (int w = 0; w < 100; w++) begin
         @(negedge clk);
         if (a_ready[1]) begin
            got = 1'b1;
            break;
         end
      end
      checks++;
      if (!got) begin
         errors++;
         $display("FAIL midreset_ready: ready[1]=%b required 1", a_ready[1]);
      end
      @(posedge clk);
      #1;
      set_req(0, 1, 1'b0, 8'h00);
      repeat (11) @(negedge clk);
      checks++;
      if (a_tx !== 1'b0) begin
         errors++;
         $display("FAIL midreset_pre: tx=%b required 0 in data bit 0", a_tx);
      end
      #2;
      a_rst_n = 1'b0;
      #1;
      checks++;
      if ({a_tx, a_busy, a_ready} !== 6'b100000) begin
         errors++;
         $display("FAIL async_reset: tx/busy/ready=%b required 100000", {a_tx, a_busy, a_ready});
      end
      $display("midreset: reset applied during data bit 0, tx=%b", a_tx);
      repeat (2) @(posedge clk);
      #1;
      a_rst_n = 1'b1;
      expect_byte(0, 8'h3C, 1, 0);
      fork
         drive_req(0, 1, b, 1, 0);
         consume(1);
      join
   endtask

   initial begin
      a_rst_n = 1'b0;
      b_rst_n = 1'b0;
      a_valid = '0;
      b_valid = '0;
      a_data  = '0;
      b_data  = '0;
      test_reset();
      test_pattern_55();
      test_round_robin();
      test_line_lock();
      test_lock_timeout();
      test_reset_mid_frame();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
